n_line_cache: RTL

- Parametrised direct-mapped, write-through, no-write-allocate cache that sits between the pipeline and a backing RAM.
- Next generation of the fixed 4-line cache. Same CPU-side odv stall contract, with generic width and depth added.
- Adds a memory-side ack handshake so RAM latency is variable, plus a flush input and hit/miss statistics counters.
- Instantiated twice in the top level: instruction side (d_width 16) and data side (d_width 8).

---
 rtl/n_line_cache_pkg.sv | 21 ++
 rtl/n_line_cache_if.sv | 30 +++
 rtl/n_line_cache_array.sv | 54 +++++
 rtl/n_line_cache.sv | 121 ++++++++++++
 4 files changed

// File: rtl/n_line_cache_pkg.sv
// Shared definitions for the direct-mapped write-through cache: FSM state
// encoding and the index-width helper.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        WDONE = 2'd3
    } state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/n_line_cache_if.sv
// CPU-side request/response and backing-RAM handshake bundle for n_line_cache.
// The cache connects through 'slave'; the requester/RAM environment uses 'master'.
interface n_line_cache_if #(
    parameter int d_width = 8,
    parameter int a_width = 8
);
    logic [a_width-1:0] cpu_addr;
    logic [d_width-1:0] cpu_din;
    logic               cpu_rd;
    logic               cpu_wr;
    logic               flush;
    logic [d_width-1:0] cpu_dout;
    logic               odv;
    logic [a_width-1:0] mem_addr;
    logic [d_width-1:0] mem_dout;
    logic [d_width-1:0] mem_din;
    logic               mem_rd;
    logic               mem_wr;
    logic               mem_ack;

    modport slave (
        input  cpu_addr, cpu_din, cpu_rd, cpu_wr, flush, mem_din, mem_ack,
        output cpu_dout, odv, mem_addr, mem_dout, mem_rd, mem_wr
    );

    modport master (
        output cpu_addr, cpu_din, cpu_rd, cpu_wr, flush, mem_din, mem_ack,
        input  cpu_dout, odv, mem_addr, mem_dout, mem_rd, mem_wr
    );
endinterface

// File: rtl/n_line_cache_array.sv
// Valid/tag/data storage for a direct-mapped cache with a combinational hit
// compare on the request address and a single fill/update write port.
module cache_line_array
    import cache_pkg::*;
#(
    parameter int d_width = 8,
    parameter int a_width = 8,
    parameter int lines   = 4
) (
    input  logic               g_clk,
    input  logic               g_clr,
    input  logic               i_clear_all,
    input  logic               i_fill_en,
    input  logic               i_upd_en,
    input  logic [a_width-1:0] i_addr,
    input  logic [d_width-1:0] i_wr_data,
    output logic               o_hit,
    output logic [d_width-1:0] o_rd_data
);
    localparam int IDX_W = clog2(lines);
    localparam int TAG_W = a_width - IDX_W;

    logic [lines-1:0]   r_valid;
    logic [TAG_W-1:0]   r_tag  [lines];
    logic [d_width-1:0] r_data [lines];
    logic [IDX_W-1:0]   w_idx;
    logic [TAG_W-1:0]   w_tag;

    assign w_idx = i_addr[IDX_W-1:0];
    assign w_tag = i_addr[a_width-1:IDX_W];

    always_ff @(posedge g_clk or posedge g_clr) begin
        if (g_clr) begin
            r_valid <= '0;
        end else if (i_clear_all) begin
            r_valid <= '0;
        end else if (i_fill_en) begin
            r_valid[w_idx] <= 1'b1;
        end
    end

    // Tag and data carry no reset; a line is only trusted once its valid bit is set.
    always_ff @(posedge g_clk) begin
        if (i_fill_en) begin
            r_tag[w_idx]  <= w_tag;
            r_data[w_idx] <= i_wr_data;
        end else if (i_upd_en) begin
            r_data[w_idx] <= i_wr_data;
        end
    end

    assign o_hit     = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign o_rd_data = o_hit ? r_data[w_idx] : '0;
endmodule

// File: rtl/n_line_cache.sv
// Direct-mapped, write-through, no-write-allocate cache: request FSM, RAM
// handshake and saturating read hit/miss statistics.
module n_line_cache
    import cache_pkg::*;
#(
    parameter int d_width   = 8,
    parameter int a_width   = 8,
    parameter int lines     = 4,
    parameter int cnt_width = 8
) (
    input  logic                 g_clk,
    input  logic                 g_clr,
    n_line_cache_if.slave        cache_bus,
    output logic [cnt_width-1:0] hit_cnt,
    output logic [cnt_width-1:0] miss_cnt
);
    state_t               r_state;
    state_t               w_next;
    logic                 w_hit;
    logic [d_width-1:0]   w_line_data;
    logic [d_width-1:0]   w_wr_data;
    logic                 w_flush;
    logic                 w_fill_en;
    logic                 w_upd_en;
    logic                 w_hit_inc;
    logic                 w_miss_inc;
    logic [cnt_width-1:0] r_hit_cnt;
    logic [cnt_width-1:0] r_miss_cnt;

    function automatic logic [cnt_width-1:0] sat_inc(input logic [cnt_width-1:0] value);
        return (&value) ? value : value + {{(cnt_width-1){1'b0}}, 1'b1};
    endfunction

    // A fill takes its word from RAM; a write-hit update takes the CPU word.
    assign w_wr_data = (r_state == FILL) ? cache_bus.mem_din : cache_bus.cpu_din;

    cache_line_array #(
        .d_width (d_width),
        .a_width (a_width),
        .lines   (lines)
    ) u_lines (
        .g_clk       (g_clk),
        .g_clr       (g_clr),
        .i_clear_all (w_flush),
        .i_fill_en   (w_fill_en),
        .i_upd_en    (w_upd_en),
        .i_addr      (cache_bus.cpu_addr),
        .i_wr_data   (w_wr_data),
        .o_hit       (w_hit),
        .o_rd_data   (w_line_data)
    );

    always_ff @(posedge g_clk or posedge g_clr) begin
        if (g_clr) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next           = r_state;
        w_flush          = 1'b0;
        w_fill_en        = 1'b0;
        w_upd_en         = 1'b0;
        w_hit_inc        = 1'b0;
        w_miss_inc       = 1'b0;
        cache_bus.odv    = 1'b0;
        cache_bus.mem_rd = 1'b0;
        cache_bus.mem_wr = 1'b0;
        case (r_state)
            IDLE: begin
                if (cache_bus.flush) begin
                    w_flush = 1'b1;
                end else if (cache_bus.cpu_wr) begin
                    w_next = WRITE;
                end else if (cache_bus.cpu_rd) begin
                    if (w_hit) begin
                        cache_bus.odv = 1'b1;
                        w_hit_inc     = 1'b1;
                    end else begin
                        w_next     = FILL;
                        w_miss_inc = 1'b1;
                    end
                end
            end
            FILL: begin
                cache_bus.mem_rd = 1'b1;
                if (cache_bus.mem_ack) begin
                    w_fill_en = 1'b1;
                    w_next    = IDLE;
                end
            end
            WRITE: begin
                cache_bus.mem_wr = 1'b1;
                if (cache_bus.mem_ack) begin
                    w_upd_en = w_hit;
                    w_next   = WDONE;
                end
            end
            WDONE: begin
                cache_bus.odv = 1'b1;
                w_next        = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge g_clk or posedge g_clr) begin
        if (g_clr) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_hit_inc)  r_hit_cnt  <= sat_inc(r_hit_cnt);
            if (w_miss_inc) r_miss_cnt <= sat_inc(r_miss_cnt);
        end
    end

    assign cache_bus.mem_addr = cache_bus.cpu_addr;
    assign cache_bus.mem_dout = cache_bus.cpu_din;
    assign cache_bus.cpu_dout = w_line_data;
    assign hit_cnt            = r_hit_cnt;
    assign miss_cnt           = r_miss_cnt;
endmodule
